// File: rtl/regfile_wb_sched_pkg.sv
// Shared encodings and write-select formatting for the register-file writeback path.
// Pure definitions: no latency, no flow control.
package regfile_wb_sched_pkg;

  typedef logic [2:0] reg_idx_t;

  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_BGE = 2'b11;
  localparam logic [1:0] CLS_MEM = 2'b00;

  localparam logic [4:0] SUB_ST = 5'b00000;
  localparam logic [4:0] SUB_LD = 5'b00001;

  localparam logic [1:0] WSEL_LD_TAG  = 2'b00;
  localparam logic [1:0] WSEL_ALU_TAG = 2'b01;

  typedef struct packed {
    reg_idx_t    rd;
    logic [15:0] dat;
  } wb_ent_t;

  function automatic logic [15:0] wsel_ld(input reg_idx_t rd);
    return {WSEL_LD_TAG, rd, 6'b0, SUB_LD};
  endfunction

  function automatic logic [15:0] wsel_alu(input reg_idx_t rd);
    return {WSEL_ALU_TAG, rd, 11'b0};
  endfunction

  // Branches and ST carry no destination; every other encoding writes [13:11].
  function automatic logic inst_has_dst(input logic [1:0] cls, input logic [4:0] sub);
    if (cls == CLS_BR || cls == CLS_BGE) return 1'b0;
    if (cls == CLS_MEM && sub == SUB_ST) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_wb_fifo.sv
// Synchronous {rd, data} FIFO; one-cycle write-to-read latency, head visible combinationally.
// Caller must not push when full unless popping, nor pop when empty.
module wb_fifo
  import regfile_wb_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    CLK,
  input  logic    RST,
  input  logic    push,
  input  wb_ent_t push_dat,
  input  logic    pop,
  output wb_ent_t head_dat,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  wb_ent_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign head_dat = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Shares the register file write port between load return (highest) and ALU writeback; port
// driven one cycle after arbitration. Loads never stall; ALU back-pressured via alu_ready.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dec_valid,
  input  logic [15:0] dec_inst,
  input  logic [2:0]  dec_src_a,
  input  logic [2:0]  dec_src_b,
  input  logic        dec_use_a,
  input  logic        dec_use_b,
  output logic        dec_ready,
  input  logic        alu_valid,
  input  logic [2:0]  alu_rd,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [2:0]  mem_rd,
  input  logic [15:0] mem_data,
  output logic        rf_load,
  output logic [15:0] rf_wsel,
  output logic [15:0] rf_d_a,
  output logic [15:0] rf_d_d,
  output logic [7:0]  busy,
  output logic        wb_err
);

  logic     dec_has_dst;
  reg_idx_t dec_dst;
  logic     issue;

  logic     fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_ent_t  fifo_head;

  logic        win_vld, win_ld;
  reg_idx_t    win_rd;
  logic [15:0] win_dat;
  logic        err_now;
  reg_idx_t    wb_rd;
  logic [7:0]  busy_nxt;

  assign dec_dst     = dec_inst[13:11];
  assign dec_has_dst = inst_has_dst(dec_inst[15:14], dec_inst[4:0]);

  // No bypass: a register whose write is on the port this cycle still reads as busy.
  assign dec_ready = !(dec_use_a && busy[dec_src_a]) &&
                     !(dec_use_b && busy[dec_src_b]) &&
                     !(dec_has_dst && busy[dec_dst]);
  assign issue = dec_valid && dec_ready;

  assign fifo_pop  = !mem_valid && !fifo_empty;
  assign alu_ready = !fifo_full || fifo_pop;
  assign fifo_push = alu_valid && alu_ready && (mem_valid || !fifo_empty);

  wb_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (fifo_push),
    .push_dat ('{rd: alu_rd, dat: alu_data}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    win_vld = 1'b0;
    win_ld  = 1'b0;
    win_rd  = '0;
    win_dat = '0;
    if (mem_valid) begin
      win_vld = 1'b1;
      win_ld  = 1'b1;
      win_rd  = mem_rd;
      win_dat = mem_data;
    end else if (!fifo_empty) begin
      win_vld = 1'b1;
      win_rd  = fifo_head.rd;
      win_dat = fifo_head.dat;
    end else if (alu_valid) begin
      win_vld = 1'b1;
      win_rd  = alu_rd;
      win_dat = alu_data;
    end
  end

  assign err_now = (win_vld && !busy[win_rd]) || (mem_valid && fifo_full);

  // Clear for the write on the port now, then set for a new issue so set wins a collision.
  always_comb begin
    busy_nxt = busy;
    if (rf_load) busy_nxt[wb_rd] = 1'b0;
    if (issue && dec_has_dst) busy_nxt[dec_dst] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_load <= 1'b0;
      rf_wsel <= '0;
      rf_d_a  <= '0;
      rf_d_d  <= '0;
      wb_rd   <= '0;
      busy    <= '0;
      wb_err  <= 1'b0;
    end else begin
      rf_load <= win_vld;
      busy    <= busy_nxt;
      wb_err  <= wb_err | err_now;
      if (win_vld) begin
        wb_rd <= win_rd;
        if (win_ld) begin
          rf_wsel <= wsel_ld(win_rd);
          rf_d_d  <= win_dat;
        end else begin
          rf_wsel <= wsel_alu(win_rd);
          rf_d_a  <= win_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: hand-computed expectations checked with immediate assertions.
module tb_regfile_wb_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dec_valid;
  logic [15:0] dec_inst;
  logic [2:0]  dec_src_a, dec_src_b;
  logic        dec_use_a, dec_use_b;
  logic        dec_ready;
  logic        alu_valid;
  logic [2:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [2:0]  mem_rd;
  logic [15:0] mem_data;
  logic        rf_load;
  logic [15:0] rf_wsel, rf_d_a, rf_d_d;
  logic [7:0]  busy;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  regfile_wb_sched #(.ALU_FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .dec_valid(dec_valid), .dec_inst(dec_inst),
    .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
    .dec_use_a(dec_use_a), .dec_use_b(dec_use_b),
    .dec_ready(dec_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_load(rf_load), .rf_wsel(rf_wsel), .rf_d_a(rf_d_a), .rf_d_d(rf_d_d),
    .busy(busy), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_inst = 16'h0; dec_src_a = 0; dec_src_b = 0;
    dec_use_a = 0; dec_use_b = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 16'h0;
    mem_valid = 0; mem_rd = 0; mem_data = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    tick();
    tick();
    RST = 0;
  endtask

  // Issue one instruction per cycle: LD for r0..r3, ADD for r4..r7.
  task automatic issue_all();
    for (int r = 0; r < 8; r++) begin
      dec_valid = 1;
      dec_inst  = (16'(r) << 11) | ((r < 4) ? 16'h0001 : 16'h0002);
      tick();
    end
    dec_valid = 0;
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    do_reset();
    #1;
    chk("reset_busy", busy, 8'h00);
    chk("reset_rf_load", rf_load, 1'b0);
    chk("reset_wsel", rf_wsel, 16'h0000);
    chk("reset_d_a", rf_d_a, 16'h0000);
    chk("reset_d_d", rf_d_d, 16'h0000);
    chk("reset_wb_err", wb_err, 1'b0);
    chk("reset_alu_ready", alu_ready, 1'b1);

    // ADD r3, then its ALU writeback
    dec_valid = 1; dec_inst = 16'h1802;
    #1 chk("add_r3_ready", dec_ready, 1'b1);
    tick();
    dec_valid = 0;
    chk("add_r3_busy", busy, 8'h08);
    alu_valid = 1; alu_rd = 3; alu_data = 16'h1234;
    #1 chk("alu_r3_ready", alu_ready, 1'b1);
    tick();
    alu_valid = 0;
    chk("alu_r3_load", rf_load, 1'b1);
    chk("alu_r3_wsel", rf_wsel, 16'h5800);
    chk("alu_r3_d_a", rf_d_a, 16'h1234);
    chk("alu_r3_busy_held", busy, 8'h08);
    tick();
    chk("alu_r3_busy_clr", busy, 8'h00);
    chk("idle_load", rf_load, 1'b0);
    chk("idle_wsel_hold", rf_wsel, 16'h5800);

    // LD r2 with a RAW consumer of r2
    dec_valid = 1; dec_inst = 16'h1001;
    tick();
    chk("ld_r2_busy", busy, 8'h04);
    dec_inst = 16'h2802; dec_use_a = 1; dec_src_a = 2;
    mem_valid = 1; mem_rd = 2; mem_data = 16'hBEEF;
    #1 chk("raw_stall0", dec_ready, 1'b0);
    tick();
    mem_valid = 0;
    #1 chk("raw_stall_nobypass", dec_ready, 1'b0);
    chk("ld_r2_load", rf_load, 1'b1);
    chk("ld_r2_wsel", rf_wsel, 16'h1001);
    chk("ld_r2_d_d", rf_d_d, 16'hBEEF);
    tick();
    chk("raw_release", dec_ready, 1'b1);
    chk("raw_busy", busy, 8'h00);
    tick();
    idle_inputs();
    chk("add_r5_busy", busy, 8'h20);

    // Stall rules against busy=0x32
    dec_valid = 1; dec_inst = 16'h0801; tick();
    dec_inst = 16'h2002; tick();
    chk("busy_32", busy, 8'h32);
    dec_inst = 16'hA002;
    #1 chk("bnz_no_dst", dec_ready, 1'b1);
    dec_inst = 16'h2002;
    #1 chk("waw_stall", dec_ready, 1'b0);
    dec_inst = 16'h0000; dec_use_b = 1; dec_src_b = 1;
    #1 chk("st_src_b_stall", dec_ready, 1'b0);
    idle_inputs();

    // mem and ALU collide: mem first, ALU next cycle
    mem_valid = 1; mem_rd = 1; mem_data = 16'h0001;
    alu_valid = 1; alu_rd = 4; alu_data = 16'h0004;
    #1 chk("collide_alu_ready", alu_ready, 1'b1);
    tick();
    idle_inputs();
    chk("collide_mem_wsel", rf_wsel, 16'h0801);
    chk("collide_mem_d_d", rf_d_d, 16'h0001);
    tick();
    chk("collide_alu_load", rf_load, 1'b1);
    chk("collide_alu_wsel", rf_wsel, 16'h6000);
    chk("collide_alu_d_a", rf_d_a, 16'h0004);
    chk("collide_d_d_hold", rf_d_d, 16'h0001);
    tick();
    chk("collide_idle", rf_load, 1'b0);
    chk("collide_busy", busy, 8'h20);
    chk("collide_no_err", wb_err, 1'b0);

    // Sustained mem traffic fills the FIFO, then ALU results drain in order
    do_reset();
    issue_all();
    chk("fill_busy_ff", busy, 8'hFF);
    for (int c = 1; c <= 10; c++) begin
      logic [2:0] rd_exp;
      idle_inputs();
      if (c <= 4) begin
        mem_valid = 1; mem_rd = 3'(c - 1); mem_data = 16'hA000 + 16'(c - 1);
      end
      if (c <= 6) begin
        alu_valid = 1;
        alu_rd = (c == 1) ? 3'd4 : (c == 2) ? 3'd5 : (c == 6) ? 3'd7 : 3'd6;
        alu_data = 16'hC000 + 16'(alu_rd);
      end
      #1;
      if (c <= 6) chk($sformatf("fill_alu_ready_c%0d", c), alu_ready, (c == 3 || c == 4) ? 1'b0 : 1'b1);
      if (c >= 2 && c <= 9) begin
        rd_exp = 3'(c - 2);
        chk($sformatf("drain_load_c%0d", c), rf_load, 1'b1);
        if (c <= 5) begin
          chk($sformatf("drain_ld_wsel_c%0d", c), rf_wsel, (16'(rd_exp) << 11) | 16'h0001);
          chk($sformatf("drain_ld_dat_c%0d", c), rf_d_d, 16'hA000 + 16'(rd_exp));
        end else begin
          chk($sformatf("drain_alu_wsel_c%0d", c), rf_wsel, 16'h4000 | (16'(rd_exp) << 11));
          chk($sformatf("drain_alu_dat_c%0d", c), rf_d_a, 16'hC000 + 16'(rd_exp));
        end
      end
      if (c == 10) begin
        chk("drain_done_load", rf_load, 1'b0);
        chk("drain_done_busy", busy, 8'h00);
      end
      tick();
    end

    // Write to a register that is not busy raises the sticky error
    do_reset();
    chk("err_clear_after_rst", wb_err, 1'b0);
    alu_valid = 1; alu_rd = 5; alu_data = 16'h5555;
    tick();
    idle_inputs();
    chk("err_set", wb_err, 1'b1);
    tick(); tick(); tick();
    chk("err_sticky", wb_err, 1'b1);

    // Reset while the FIFO holds two entries and all registers are busy
    issue_all();
    chk("rst_pre_busy", busy, 8'hFF);
    mem_valid = 1; mem_rd = 0; mem_data = 16'h1111;
    alu_valid = 1; alu_rd = 4; alu_data = 16'h4444;
    tick();
    mem_rd = 1; mem_data = 16'h2222; alu_rd = 5; alu_data = 16'h5555;
    tick();
    idle_inputs();
    RST = 1;
    tick();
    RST = 0;
    chk("rst_busy", busy, 8'h00);
    chk("rst_load", rf_load, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_wb_err", wb_err, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_no_stale_write%0d", k), rf_load, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
